// File: rtl/tick_gen.sv
// tick_gen: multi-channel programmable tick generator.
//
// Every channel divides clk by its own divisor register. In periodic mode it
// produces a one-cycle tick every div cycles. In one-shot mode it produces a
// single tick and then parks in HALT until its divisor is reloaded.
//
// Parameters
//   WIDTH       - counter and divisor width in bits
//   CHANNELS    - number of independent tick channels
//   DEFAULT_DIV - divisor value held in every channel after reset
//
// Ports
//   clk     in   sole clock; all state updates on its rising edge
//   reset   in   asynchronous, active-high reset
//   en      in   [CHANNELS] per-channel count enable
//   load    in   [CHANNELS] per-channel strobe: div <= div_in, cnt <= 0, re-arm
//   div_in  in   [WIDTH]    divisor value shared by all channels (0 is stored as 1)
//   oneshot in   [CHANNELS] 0 = periodic, 1 = halt after the next tick
//   sync    in   clears every channel counter together (phase alignment)
//   tick    out  [CHANNELS] registered single-cycle pulse
//   sq      out  [CHANNELS] registered square wave, toggles on every tick
//   halted  out  [CHANNELS] high while a one-shot channel waits for re-arm
module tick_gen #(
    parameter int unsigned WIDTH       = 27,
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned DEFAULT_DIV = 33333334
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] en,
    input  logic [CHANNELS-1:0] load,
    input  logic [WIDTH-1:0]    div_in,
    input  logic [CHANNELS-1:0] oneshot,
    input  logic                sync,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] sq,
    output logic [CHANNELS-1:0] halted
);

    // Channel states
    localparam logic [0:0] StRun  = 1'b0;
    localparam logic [0:0] StHalt = 1'b1;

    // A divisor of 0 has no meaningful period; it behaves as 1.
    localparam logic [WIDTH-1:0] ResetDiv =
        (DEFAULT_DIV == 0) ? WIDTH'(1) : WIDTH'(DEFAULT_DIV);

    logic [CHANNELS-1:0][WIDTH-1:0] div_q, div_d;
    logic [CHANNELS-1:0][WIDTH-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0]            state_q, state_d;
    logic [CHANNELS-1:0]            tick_q, tick_d;
    logic [CHANNELS-1:0]            sq_q, sq_d;
    logic [WIDTH-1:0]               load_div;

    assign load_div = (div_in == '0) ? WIDTH'(1) : div_in;

    // Per-channel next state. Priority: load > sync > halt hold > enable gating >
    // terminal count > increment. Reset is handled in the register block.
    always_comb begin
        div_d   = div_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        tick_d  = '0;
        sq_d    = sq_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (load[i]) begin
                div_d[i]   = load_div;
                cnt_d[i]   = '0;
                state_d[i] = StRun;
            end else if (sync) begin
                cnt_d[i] = '0;
            end else if (state_q[i] == StHalt) begin
                cnt_d[i] = '0;
            end else if (en[i]) begin
                // >= rather than == so a counter can never run past div-1 and
                // wrap through 2^WIDTH, whatever the divisor history.
                if (cnt_q[i] >= div_q[i] - WIDTH'(1)) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    sq_d[i]   = ~sq_q[i];
                    if (oneshot[i]) begin
                        state_d[i] = StHalt;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= {CHANNELS{ResetDiv}};
            cnt_q   <= '0;
            state_q <= {CHANNELS{StRun}};
            tick_q  <= '0;
            sq_q    <= '0;
        end else begin
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            tick_q  <= tick_d;
            sq_q    <= sq_d;
        end
    end

    always_comb begin
        halted = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            halted[i] = (state_q[i] == StHalt);
        end
    end

    assign tick = tick_q;
    assign sq   = sq_q;

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: directed scenarios plus a randomized run,
// all compared cycle by cycle against a behavioural model that counts enabled
// edges since the last restart of each channel.
module tb_tick_gen;

    localparam int W = 27;
    localparam int C = 2;
    localparam int DEF_DIV = 33333334;

    logic         clk;
    logic         reset;
    logic [C-1:0] en;
    logic [C-1:0] load;
    logic [W-1:0] div_in;
    logic [C-1:0] oneshot;
    logic         sync;
    logic [C-1:0] tick;
    logic [C-1:0] sq;
    logic [C-1:0] halted;

    // Small second instance to see the reset divisor produce its first tick.
    logic [0:0] en2;
    logic [0:0] tick2;
    logic [0:0] sq2;
    logic [0:0] halted2;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_div[C];
    int m_n[C];
    bit m_halt[C];
    bit m_sq[C];
    bit m_tick[C];

    tick_gen #(.WIDTH(W), .CHANNELS(C), .DEFAULT_DIV(DEF_DIV)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .div_in(div_in),
        .oneshot(oneshot), .sync(sync), .tick(tick), .sq(sq), .halted(halted)
    );

    tick_gen #(.WIDTH(8), .CHANNELS(1), .DEFAULT_DIV(7)) dut2 (
        .clk(clk), .reset(reset), .en(en2), .load(1'b0), .div_in(8'd0),
        .oneshot(1'b0), .sync(1'b0), .tick(tick2), .sq(sq2), .halted(halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < C; i++) begin
            m_div[i] = DEF_DIV; m_n[i] = 0; m_halt[i] = 0; m_sq[i] = 0; m_tick[i] = 0;
        end
    endtask

    // A tick happens on the div-th enabled edge after a restart (reset, load,
    // sync or previous tick); one-shot channels then ignore everything but load.
    task automatic model_step();
        for (int i = 0; i < C; i++) begin
            m_tick[i] = 0;
            if (load[i]) begin
                m_div[i]  = (div_in == 0) ? 1 : int'(div_in);
                m_n[i]    = 0;
                m_halt[i] = 0;
            end else if (sync) begin
                m_n[i] = 0;
            end else if (!m_halt[i] && en[i]) begin
                m_n[i]++;
                if (m_n[i] == m_div[i]) begin
                    m_n[i]    = 0;
                    m_tick[i] = 1;
                    m_sq[i]   = !m_sq[i];
                    if (oneshot[i]) m_halt[i] = 1;
                end
            end
        end
    endtask

    task automatic compare_model();
        logic [C-1:0] et, es, eh;
        for (int i = 0; i < C; i++) begin
            et[i] = m_tick[i]; es[i] = m_sq[i]; eh[i] = m_halt[i];
        end
        check("tick", 32'(tick), 32'(et));
        check("sq", 32'(sq), 32'(es));
        check("halted", 32'(halted), 32'(eh));
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic cyc(input logic [C-1:0] e, input logic [C-1:0] l, input logic [C-1:0] o,
                       input logic s, input logic [W-1:0] d);
        en = e; load = l; oneshot = o; sync = s; div_in = d;
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    // Clock until channel ch ticks; k is the edge number (or -1 if the bound ran out).
    task automatic run_until_tick(input int ch, input logic [C-1:0] e, input logic [C-1:0] o,
                                  input int bound, output int k);
        k = -1;
        for (int i = 1; i <= bound; i++) begin
            cyc(e, '0, o, 1'b0, '0);
            if (tick[ch]) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        compare_model();
        reset = 1'b0;
    endtask

    initial begin
        int k, cnt, f0, f1, both;
        en = '0; load = '0; oneshot = '0; sync = 1'b0; div_in = '0; en2 = 1'b1;
        reset = 1'b1;
        model_reset();
        #2;
        check("reset_tick", 32'(tick), 0);
        check("reset_sq", 32'(sq), 0);
        check("reset_halted", 32'(halted), 0);
        do_reset();

        // Default divisor: small instance ticks on edge 7; big one stays quiet.
        k = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc('1, '0, '0, 1'b0, '0);
            if (tick2[0] && k < 0) begin
                k = i;
                check("default_sq2", 32'(sq2), 1);
            end
        end
        check("default_first_tick", k, 7);

        // Periodic div=4: one tick every 4 edges, sq period 8.
        cyc('1, 2'b01, '0, 1'b0, 4);
        check("load_no_tick", 32'(tick[0]), 0);
        cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            cyc('1, '0, '0, 1'b0, '0);
            if (tick[0]) cnt++;
            if (i == 4) check("period4_first", 32'(tick[0]), 1);
        end
        check("period4_count", cnt, 4);

        // One-shot div=3.
        cyc('1, 2'b01, 2'b01, 1'b0, 3);
        run_until_tick(0, '1, 2'b01, 10, k);
        check("oneshot_first", k, 3);
        check("oneshot_halted", 32'(halted[0]), 1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc('1, '0, 2'b01, 1'b0, '0);
            if (tick[0]) cnt++;
        end
        check("oneshot_silent", cnt, 0);
        cyc('1, 2'b01, 2'b01, 1'b0, 3);
        check("rearm_halted", 32'(halted[0]), 0);
        run_until_tick(0, '1, 2'b01, 10, k);
        check("rearm_tick", k, 3);

        // div_in = 0 behaves as 1: tick every edge.
        cyc('1, 2'b01, '0, 1'b0, 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cyc('1, '0, '0, 1'b0, '0);
            if (tick[0]) cnt++;
        end
        check("div0_count", cnt, 6);

        // Load on the terminal-count edge wins: no tick, restart from 0.
        cyc('1, 2'b01, '0, 1'b0, 3);
        cyc('1, '0, '0, 1'b0, '0);
        cyc('1, '0, '0, 1'b0, '0);
        cyc('1, 2'b01, '0, 1'b0, 3);
        check("load_at_tc_tick", 32'(tick[0]), 0);
        run_until_tick(0, '1, '0, 10, k);
        check("load_at_tc_next", k, 3);

        // Enable gating with div=6: hold at cnt=2 for 5 edges.
        cyc('1, 2'b01, '0, 1'b0, 6);
        cyc('1, '0, '0, 1'b0, '0);
        cyc('1, '0, '0, 1'b0, '0);
        for (int i = 0; i < 5; i++) cyc(2'b10, '0, '0, 1'b0, '0);
        run_until_tick(0, '1, '0, 10, k);
        check("gated_tick", k, 4);

        // Sync aligns ch0 (div 4) and ch1 (div 8).
        cyc('1, 2'b01, '0, 1'b0, 4);
        for (int i = 0; i < 3; i++) cyc('1, '0, '0, 1'b0, '0);
        cyc('1, 2'b10, '0, 1'b0, 8);
        for (int i = 0; i < 5; i++) cyc('1, '0, '0, 1'b0, '0);
        cyc('1, '0, '0, 1'b1, '0);
        check("sync_no_tick", 32'(tick), 0);
        f0 = -1; f1 = -1; both = 0;
        for (int i = 1; i <= 16; i++) begin
            cyc('1, '0, '0, 1'b0, '0);
            if (tick[0] && f0 < 0) f0 = i;
            if (tick[1] && f1 < 0) f1 = i;
            if (tick == 2'b11) both++;
        end
        check("sync_ch0_first", f0, 4);
        check("sync_ch1_first", f1, 8);
        check("sync_coincide", both, 2);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [C-1:0] e, l, o;
            for (int c = 0; c < C; c++) begin
                e[c] = ($urandom_range(0, 3) != 0);
                l[c] = ($urandom_range(0, 15) == 0);
                o[c] = ($urandom_range(0, 7) == 0);
            end
            cyc(e, l, o, ($urandom_range(0, 39) == 0), W'($urandom_range(0, 9)));
        end

        // Asynchronous reset mid-cycle: outputs clear before any clock edge.
        cyc('1, 2'b11, '0, 1'b0, 2);
        cyc('1, '0, '0, 1'b0, '0);
        cyc('1, '0, '0, 1'b0, '0);
        #2;
        reset = 1'b1;
        #1;
        check("async_tick", 32'(tick), 0);
        check("async_sq", 32'(sq), 0);
        check("async_halted", 32'(halted), 0);
        do_reset();
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            cyc('1, '0, '0, 1'b0, '0);
            if (tick != 0) cnt++;
        end
        check("post_reset_quiet", cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
